// File: rtl/hci_package.sv
// rtl/hci_package.sv - shared constants for the HCI fault monitoring slice
package hci_package;

  localparam int HCI_FAULT_CNT_W_DEFAULT = 8;

endpackage

// File: rtl/hci_fault_counter.sv
// rtl/hci_fault_counter.sv - saturating up-counter with clear; clear-with-inc loads 1
module hci_fault_counter #(
  parameter int W = 8
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         inc_i,
  input  logic         clr_i,
  output logic [W-1:0] cnt_o,
  output logic [W-1:0] cnt_next_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = {{(W-1){1'b0}}, inc_i};
    end else if (inc_i && (cnt_q != {W{1'b1}})) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt_o      = cnt_q;
  assign cnt_next_o = cnt_d;

endmodule

// File: rtl/hci_fault_monitor.sv
// rtl/hci_fault_monitor.sv - collects HCI copy-pair fault lines into sticky status, counters, first index and fatal flag
module hci_fault_monitor
  import hci_package::*;
#(
  parameter  int N_FAULT = 4,
  parameter  int CNT_W   = HCI_FAULT_CNT_W_DEFAULT,
  parameter  bit REG_IN  = 1'b1,
  localparam int IDX_W   = (N_FAULT > 1) ? $clog2(N_FAULT) : 1
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [N_FAULT-1:0]       fault_i,
  input  logic [N_FAULT-1:0]       mask_i,
  input  logic [N_FAULT-1:0]       clear_i,
  input  logic                     clear_all_i,
  input  logic [CNT_W-1:0]         threshold_i,
  output logic [N_FAULT-1:0]       status_o,
  output logic [N_FAULT*CNT_W-1:0] count_o,
  output logic [CNT_W-1:0]         total_count_o,
  output logic                     first_valid_o,
  output logic [IDX_W-1:0]         first_idx_o,
  output logic                     irq_o,
  output logic                     fatal_o
);

  logic [N_FAULT-1:0] fault_s, f_eff, line_clr;
  logic [N_FAULT-1:0] status_q, status_d;
  logic               first_valid_q, first_valid_d;
  logic [IDX_W-1:0]   first_idx_q, first_idx_d, lowest_idx;
  logic               irq_q, irq_d;
  logic               fatal_q, fatal_d;
  logic [CNT_W-1:0]   total_next;
  logic               any_fault;

  if (REG_IN) begin : g_reg_in
    logic [N_FAULT-1:0] fault_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        fault_q <= '0;
      end else begin
        fault_q <= fault_i;
      end
    end
    assign fault_s = fault_q;
  end else begin : g_direct_in
    assign fault_s = fault_i;
  end

  // Mask is applied to the already-staged fault, so it acts without delay.
  assign f_eff     = fault_s & ~mask_i;
  assign any_fault = |f_eff;
  assign line_clr  = clear_i | {N_FAULT{clear_all_i}};

  for (genvar k = 0; k < N_FAULT; k++) begin : g_line_cnt
    hci_fault_counter #(.W(CNT_W)) u_line_cnt (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .inc_i      (f_eff[k]),
      .clr_i      (line_clr[k]),
      .cnt_o      (count_o[k*CNT_W +: CNT_W]),
      .cnt_next_o ()
    );
  end

  hci_fault_counter #(.W(CNT_W)) u_total_cnt (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .inc_i      (any_fault),
    .clr_i      (clear_all_i),
    .cnt_o      (total_count_o),
    .cnt_next_o (total_next)
  );

  always_comb begin
    lowest_idx = '0;
    for (int k = N_FAULT - 1; k >= 0; k--) begin
      if (f_eff[k]) lowest_idx = IDX_W'(k);
    end
  end

  always_comb begin
    status_d      = (status_q & ~line_clr) | f_eff;
    irq_d         = |status_d;
    first_valid_d = first_valid_q & ~clear_all_i;
    first_idx_d   = clear_all_i ? '0 : first_idx_q;
    if (!first_valid_d && any_fault) begin
      first_valid_d = 1'b1;
      first_idx_d   = lowest_idx;
    end
    fatal_d = fatal_q & ~clear_all_i;
    if ((threshold_i != '0) && (total_next >= threshold_i)) fatal_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      status_q      <= '0;
      first_valid_q <= 1'b0;
      first_idx_q   <= '0;
      irq_q         <= 1'b0;
      fatal_q       <= 1'b0;
    end else begin
      status_q      <= status_d;
      first_valid_q <= first_valid_d;
      first_idx_q   <= first_idx_d;
      irq_q         <= irq_d;
      fatal_q       <= fatal_d;
    end
  end

  assign status_o      = status_q;
  assign first_valid_o = first_valid_q;
  assign first_idx_o   = first_idx_q;
  assign irq_o         = irq_q;
  assign fatal_o       = fatal_q;

endmodule

// File: tb/tb_hci_fault_monitor.sv
// tb/tb_hci_fault_monitor.sv - randomized self-checking bench against a behavioural model
module tb_hci_fault_monitor;

  localparam int N    = 4;
  localparam int W    = 4;
  localparam int IW   = 2;
  localparam int CMAX = (1 << W) - 1;

  logic           clk_i = 1'b0;
  logic           rst_ni = 1'b0;
  logic [N-1:0]   fault_i = '0, mask_i = '0, clear_i = '0;
  logic           clear_all_i = 1'b0;
  logic [W-1:0]   threshold_i = '0;
  logic [N-1:0]   status_o;
  logic [N*W-1:0] count_o;
  logic [W-1:0]   total_count_o;
  logic           first_valid_o;
  logic [IW-1:0]  first_idx_o;
  logic           irq_o, fatal_o;

  hci_fault_monitor #(.N_FAULT(N), .CNT_W(W), .REG_IN(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .fault_i(fault_i), .mask_i(mask_i),
    .clear_i(clear_i), .clear_all_i(clear_all_i), .threshold_i(threshold_i),
    .status_o(status_o), .count_o(count_o), .total_count_o(total_count_o),
    .first_valid_o(first_valid_o), .first_idx_o(first_idx_o),
    .irq_o(irq_o), .fatal_o(fatal_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;

  // model state: what the monitor should report, from the behavioural rules
  int       m_cnt[N];
  int       m_tot;
  bit       m_st[N];
  bit [N-1:0] m_fq;
  bit       m_fv, m_irq, m_fatal;
  int       m_fi;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < N; k++) begin
      m_cnt[k] = 0;
      m_st[k]  = 0;
    end
    m_tot = 0; m_fq = '0; m_fv = 0; m_fi = 0; m_irq = 0; m_fatal = 0;
  endtask

  task automatic model_step();
    bit [N-1:0] feff;
    bit any;
    feff = m_fq & ~mask_i;
    any  = (feff != 0);
    for (int k = 0; k < N; k++) begin
      bit clr;
      clr = clear_i[k] | clear_all_i;
      if (feff[k]) begin
        m_st[k]  = 1;
        m_cnt[k] = clr ? 1 : ((m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX);
      end else if (clr) begin
        m_st[k]  = 0;
        m_cnt[k] = 0;
      end
    end
    if (clear_all_i) m_tot = any ? 1 : 0;
    else if (any) m_tot = (m_tot < CMAX) ? m_tot + 1 : CMAX;
    if (clear_all_i) begin
      m_fv = 0;
      m_fi = 0;
    end
    if (!m_fv && any) begin
      m_fv = 1;
      for (int k = N - 1; k >= 0; k--) if (feff[k]) m_fi = k;
    end
    if (clear_all_i) m_fatal = 0;
    if (threshold_i != 0 && m_tot >= threshold_i) m_fatal = 1;
    m_irq = 0;
    for (int k = 0; k < N; k++) m_irq |= m_st[k];
    m_fq = fault_i;
  endtask

  task automatic check_model(input string tag);
    logic [N-1:0]   es;
    logic [N*W-1:0] ec;
    for (int k = 0; k < N; k++) begin
      es[k] = m_st[k];
      ec[k*W +: W] = W'(m_cnt[k]);
    end
    check_eq({tag, ".status"}, status_o, es);
    check_eq({tag, ".count"}, count_o, ec);
    check_eq({tag, ".total"}, total_count_o, m_tot);
    check_eq({tag, ".fvalid"}, first_valid_o, m_fv);
    check_eq({tag, ".fidx"}, first_idx_o, m_fv ? m_fi : 0);
    check_eq({tag, ".irq"}, irq_o, m_irq);
    check_eq({tag, ".fatal"}, fatal_o, m_fatal);
  endtask

  // inputs are set at the negedge, the model advances with the posedge
  task automatic step(input logic [N-1:0] f, input logic [N-1:0] m, input logic [N-1:0] c,
                      input logic ca, input logic [W-1:0] th, input string tag);
    fault_i = f; mask_i = m; clear_i = c; clear_all_i = ca; threshold_i = th;
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    check_model(tag);
  endtask

  initial begin
    model_reset();
    #12;
    check_model("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    // sticky status with registered input
    repeat (3) step(4'b0010, '0, '0, 0, 0, "hold");
    repeat (2) step('0, '0, '0, 0, 0, "drain");
    check_eq("tp1.status", status_o, 4'b0010);
    check_eq("tp1.cnt1", count_o[1*W +: W], 3);
    check_eq("tp1.total", total_count_o, 3);
    check_eq("tp1.fidx", first_idx_o, 1);
    check_eq("tp1.irq", irq_o, 1);

    // simultaneous lines count once globally, lowest index captured
    step('0, '0, '0, 1, 0, "ca");
    step(4'b1100, '0, '0, 0, 0, "sim");
    repeat (2) step('0, '0, '0, 0, 0, "sim2");
    check_eq("tp2.fidx", first_idx_o, 2);
    check_eq("tp2.cnt2", count_o[2*W +: W], 1);
    check_eq("tp2.cnt3", count_o[3*W +: W], 1);
    check_eq("tp2.total", total_count_o, 1);

    // saturation and threshold
    step('0, '0, '0, 1, 10, "ca2");
    for (int i = 0; i < 20; i++) begin
      step(4'b0001, '0, '0, 0, 10, "sat");
      if (i == 9) check_eq("tp3.nofatal", fatal_o, 0);
      if (i == 10) check_eq("tp3.fatal10", fatal_o, 1);
    end
    step('0, '0, '0, 0, 10, "sat2");
    check_eq("tp3.cnt0", count_o[0 +: W], 15);
    check_eq("tp3.total", total_count_o, 15);
    step('0, '0, '0, 0, 0, "thr0");
    check_eq("tp3.sticky", fatal_o, 1);

    // clear collision, then plain clear drops irq
    step('0, '0, '0, 1, 0, "ca3");
    step(4'b0010, '0, '0, 0, 0, "col0");
    step('0, '0, 4'b0010, 0, 0, "col1");
    check_eq("tp4.st1", status_o[1], 1);
    check_eq("tp4.cnt1", count_o[1*W +: W], 1);
    step('0, '0, 4'b0010, 0, 0, "col2");
    check_eq("tp4.cleared", status_o[1], 0);
    check_eq("tp4.irq", irq_o, 0);

    // masking ignores new faults and keeps old state
    repeat (6) step(4'b0001, 4'b0001, '0, 0, 0, "mask");
    check_eq("tp5.masked", status_o[0], 0);
    repeat (2) step(4'b0001, '0, '0, 0, 0, "unmask");
    repeat (3) step(4'b0001, 4'b0001, '0, 0, 0, "remask");
    check_eq("tp5.kept", status_o[0], 1);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      logic [N-1:0] f, m, c;
      logic ca;
      logic [W-1:0] th;
      f  = ($urandom_range(0, 2) == 0) ? N'($urandom) : '0;
      m  = ($urandom_range(0, 5) == 0) ? N'($urandom) : '0;
      c  = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
      ca = ($urandom_range(0, 60) == 0);
      th = ($urandom_range(0, 9) == 0) ? W'($urandom) : threshold_i;
      step(f, m, c, ca, th, "rand");
    end

    // asynchronous reset between edges during an active fault
    repeat (3) step(4'b1111, '0, '0, 0, 3, "pre_rst");
    #2 rst_ni = 1'b0;
    #1;
    model_reset();
    check_model("async_rst");
    @(negedge clk_i);
    rst_ni = 1'b1;
    repeat (4) step('0, '0, '0, 0, 0, "post_rst");
    check_eq("tp6.fatal", fatal_o, 0);
    check_eq("tp6.total", total_count_o, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
